// File: rtl/fht_row_butterfly.sv
// fht_row_butterfly
//
// First-stage butterfly for the 8-point row transform of a 2-D FHT.
// Samples of a row are collected one per accepted strobe. Once x7 of a row
// is in, the four butterfly pairs (x[i]+x[i+4], x[i]-x[i+4]) are emitted on
// four consecutive cycles. Each pair is one bit wider than the input.
// Ingest never stalls: the next row keeps filling while the previous row drains.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   din_valid  sample strobe, din accepted on every edge where it is high
//   din        signed N-bit sample
//   din_sof    start of frame (qualified by din_valid): din is x0 of row 0
//   out_valid  pair strobe
//   out_sum    signed N+1-bit x[i]+x[i+4]
//   out_diff   signed N+1-bit x[i]-x[i+4]
//   out_idx    pair index i (0..3)
//   out_row    row number of the draining row (0..7)
//   out_last   high with pair 3 of row 7 (end of frame)

module fht_row_butterfly #(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                din_valid,
    input  logic [N-1:0]        din,
    input  logic                din_sof,
    output logic                out_valid,
    output logic signed [N:0]   out_sum,
    output logic signed [N:0]   out_diff,
    output logic [1:0]          out_idx,
    output logic [2:0]          out_row,
    output logic                out_last
);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            state;
    logic [N-1:0]      bank [8];
    logic [2:0]        wr_idx;
    logic [2:0]        wr_row;
    logic [1:0]        rd_idx;
    logic [2:0]        drain_row;

    logic [2:0]        lo_addr;
    logic [2:0]        hi_addr;
    logic signed [N:0] op_lo;
    logic signed [N:0] op_hi;

    // Pair i reads bank[i] and bank[i+4]; both operands are sign-extended
    // by one bit so neither the sum nor the difference can overflow.
    assign lo_addr = {1'b0, rd_idx};
    assign hi_addr = {1'b1, rd_idx};
    assign op_lo   = {bank[lo_addr][N-1], bank[lo_addr]};
    assign op_hi   = {bank[hi_addr][N-1], bank[hi_addr]};

    // Sample bank. A start-of-frame sample always lands in slot 0. A write to
    // a slot being read on the same edge is harmless: the drain samples the
    // old register contents.
    always_ff @(posedge clk) begin
        if (din_valid) begin
            if (din_sof) begin
                bank[0] <= din;
            end else begin
                bank[wr_idx] <= din;
            end
        end
    end

    // Control and registered outputs. Row completion is evaluated after the
    // drain step so that it wins if both touch rd_idx/state on one edge.
    // The fill cadence prevents that case, but the ordering keeps it safe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= FILL;
            wr_idx    <= 3'd0;
            wr_row    <= 3'd0;
            rd_idx    <= 2'd0;
            drain_row <= 3'd0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_diff  <= '0;
            out_idx   <= 2'd0;
            out_row   <= 3'd0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= 1'b0;

            if (state == DRAIN) begin
                out_valid <= 1'b1;
                out_sum   <= op_lo + op_hi;
                out_diff  <= op_lo - op_hi;
                out_idx   <= rd_idx;
                out_row   <= drain_row;
                out_last  <= (rd_idx == 2'd3) && (drain_row == 3'd7);
                rd_idx    <= rd_idx + 2'd1;
                if (rd_idx == 2'd3) begin
                    state <= FILL;
                end
            end

            if (din_valid) begin
                if (din_sof) begin
                    // Resync: any partial row is dropped, the frame restarts.
                    wr_idx <= 3'd1;
                    wr_row <= 3'd0;
                end else begin
                    wr_idx <= wr_idx + 3'd1;
                    if (wr_idx == 3'd7) begin
                        state     <= DRAIN;
                        rd_idx    <= 2'd0;
                        drain_row <= wr_row;
                        wr_row    <= wr_row + 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/fht_row_butterfly.md
# fht_row_butterfly

Streaming first-stage butterfly for the 8-point row transform of the 2-D FHT. The block collects one row of 8 signed samples and emits the four butterfly pairs (x[i]+x[i+4], x[i]-x[i+4]), each one bit wider than the input. Its outputs feed the next row stage. The difference terms of the pairs that need sqrt(2) scaling are routed to the constant multiplier, which is instantiated with width N+1 and driven by out_valid.

## Interface
- N, 8, input sample width (two's complement); outputs are N+1 bits

- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- din_valid  in  1  sample strobe; din is accepted on every rising edge where it is high
- din  in  N  signed input sample
- din_sof  in  1  start of frame; qualified by din_valid, marks din as x0 of row 0
- out_valid  out  1  pair strobe
- out_sum  out  N+1  signed x[i]+x[i+4]
- out_diff  out  N+1  signed x[i]-x[i+4]
- out_idx  out  2  pair index i (0..3)
- out_row  out  3  row number of the draining row (0..7)
- out_last  out  1  high with pair 3 of row 7 (end of frame)

## Operation
- Storage: 8 x N sample register bank, write index wr_idx (0..7), write row counter wr_row (0..7), drain flag, drain counter rd_idx (0..3), latched drain row.
- Accept: on each edge with din_valid=1, store din at bank[wr_idx], then increment wr_idx (7 wraps to 0).
  - If din_sof=1, the sample is written to bank[0] regardless of wr_idx, wr_idx becomes 1 and wr_row becomes 0.
  - Any partial row is discarded silently.
- Row complete: when the write at wr_idx=7 is accepted:
  - set the drain flag and clear rd_idx;
  - latch wr_row as the drain row;
  - increment wr_row (7 wraps to 0).
- Drain: 4 consecutive cycles, no stall. On each edge with the drain flag set:
  - register sum/diff of bank[rd_idx] and bank[rd_idx+4];
  - register out_idx=rd_idx, out_row=drain row, out_last=(rd_idx==3 && drain row==7);
  - set out_valid=1 and increment rd_idx.
  - The drain flag clears after rd_idx=3.
- Read-before-write: new-row writes to bank[i] on the same edge that reads bank[i] must not corrupt the pair. Register semantics guarantee this.
  - The next row's x4 cannot arrive before its drain finishes.
  - Therefore ingest never stalls and there is no ready output.
- Arithmetic: sign-extend both operands to N+1 bits, then add or subtract. The result range is [-2^N, 2^N-1], so no overflow and no saturation.
- States: IDLE/FILL (drain flag 0) and DRAIN (drain flag 1, 4 cycles). Filling continues during DRAIN.
- din_sof during DRAIN: the drain completes unchanged with its latched row number. The new frame fills from x0.

## Timing
- Reset (rstn=0, asynchronous): out_valid=0, out_sum=0, out_diff=0, out_idx=0, out_row=0, out_last=0.
  - wr_idx=0, wr_row=0, drain flag cleared.
- Reset asserted mid-drain aborts the drain. No further pairs are emitted for that row.
- Let E0 be the edge that accepts x7. Pair i is registered at edge E(1+i).
  - out_valid is high in the 4 cycles after E1..E4.
  - out_valid is low after E5 unless another row has completed.
- Back-to-back rows (din_valid held high):
  - out_valid has a 4-on / 4-off pattern;
  - maximum throughput is 1 sample/cycle in, 1 pair/cycle out at 50% duty.
- Outputs hold their last values while out_valid=0. Consumers qualify them with out_valid.

## Test plan
- Single row, N=8, sof on first sample, din = 10,20,30,40,1,2,3,4 on consecutive cycles.
  - Expect out_valid for 4 cycles starting 1 cycle after x7.
  - (sum,diff) = (11,9),(22,18),(33,27),(44,36); out_idx 0..3; out_row=0.
- Extremes, N=8, pairs (x_i, x_{i+4}) = (-128,127),(127,-128),(-128,-128),(127,127).
  - Expect sums -1,-1,-256,254.
  - Expect diffs -255,255,0,0 (9-bit exact).
- 16 back-to-back samples: row A = 0..7, row B = 100..107.
  - Row A pairs are (4,-4),(6,-4),(8,-4),(10,-4), unaffected by concurrent row B writes.
  - Row B pairs are (204,-4)…(210,-4) with out_row=1.
- Full frame: 64 back-to-back samples with sof on the first.
  - out_row runs 0..7; out_last is high only on pair 3 of row 7.
  - A 65th sample without sof starts row 0 again.
- Mid-row resync: sof after 5 samples of a row, then 8 samples 1..8.
  - No pairs are emitted for the discarded partial row.
  - Expect pairs (6,-4),(8,-4),(10,-4),(12,-4) with out_row=0.
- Reset mid-drain: assert rstn=0 for 1 cycle during pair 1 of a row.
  - All outputs are 0 immediately (asynchronous).
  - Pairs 2..3 are never emitted; the next sof row drains normally.
